md_buf_ctrl: RTL

Ping-pong controller for the pre-intra mode RAM. The pre-intra mode writer fills one bank with the best modes of the current LCU while the downstream intra/mode-decision stage reads the other bank for the previous LCU. The block tracks bank ownership, gates and steers writes and reads to the two single-port mode-RAM banks, and flags protocol violations.

---
 rtl/md_buf_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/md_buf_ctrl.sv
// Ping-pong bank controller for the pre-intra mode RAM: the writer fills one
// bank while the reader drains the other. Protocol violations raise a sticky err_o.
module md_buf_ctrl #(
  parameter int AW    = 7,
  parameter int DW    = 6,
  parameter int DEPTH = 85
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lcu_start_i,
  input  logic          wr_we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_done_i,
  output logic          wr_ready_o,
  output logic          rd_valid_o,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_data_vld_o,
  input  logic          rd_release_i,
  output logic [1:0]    ram_we_o,
  output logic [1:0]    ram_re_o,
  output logic [AW-1:0] ram_addr0_o,
  output logic [AW-1:0] ram_addr1_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata0_i,
  input  logic [DW-1:0] ram_rdata1_i,
  output logic          wsel_o,
  output logic          rsel_o,
  output logic          err_o
);

  // state    | meaning
  // FREE     | bank empty, may be claimed by the writer
  // FILLING  | writer is storing modes of the current LCU
  // FULL     | complete LCU, reader has not touched it yet
  // READING  | reader has issued at least one read
  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_st_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  bank_st_e st_q [2];
  bank_st_e st_d [2];
  bank_st_e w_st;
  bank_st_e r_st;
  logic     wsel_q, wsel_d;
  logic     rsel_q, rsel_d;
  logic     err_q, err_d;
  logic     rd_pend_q;
  logic     rd_bank_q;
  logic     rd_acc;
  logic     wr_in_range;
  logic     rd_in_range;

  assign w_st        = st_q[wsel_q];
  assign r_st        = st_q[rsel_q];
  assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_L);

  assign wr_ready_o    = (w_st == FREE) || (w_st == FILLING);
  assign rd_valid_o    = (r_st == FULL) || (r_st == READING);
  assign rd_data_vld_o = rd_pend_q;
  assign rd_data_o     = rd_bank_q ? ram_rdata1_i : ram_rdata0_i;
  assign wsel_o        = wsel_q;
  assign rsel_o        = rsel_q;
  assign err_o         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]   <= FREE;
      st_q[1]   <= FREE;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      err_q     <= err_d;
      rd_pend_q <= rd_acc;
      rd_bank_q <= rsel_q;
    end
  end

  // Writer and reader never act on the same bank: each side only acts in
  // states the other side cannot, so the per-bank updates below never collide.
  always_comb begin
    st_d[0]     = st_q[0];
    st_d[1]     = st_q[1];
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    err_d       = err_q;
    rd_acc      = 1'b0;
    ram_we_o    = 2'b00;
    ram_re_o    = 2'b00;
    ram_addr0_o = '0;
    ram_addr1_o = '0;
    ram_wdata_o = '0;

    if (rd_req_i) begin
      if (rd_valid_o && rd_in_range) begin
        rd_acc           = 1'b1;
        ram_re_o[rsel_q] = 1'b1;
        if (rsel_q) ram_addr1_o = rd_addr_i;
        else        ram_addr0_o = rd_addr_i;
        if (r_st == FULL) st_d[rsel_q] = READING;
      end else begin
        err_d = 1'b1;
      end
    end

    if (wr_we_i) begin
      if ((w_st == FILLING) && wr_in_range) begin
        ram_we_o[wsel_q] = 1'b1;
        ram_wdata_o      = wr_data_i;
        if (wsel_q) ram_addr1_o = wr_addr_i;
        else        ram_addr0_o = wr_addr_i;
      end else begin
        err_d = 1'b1;
      end
    end

    if (lcu_start_i) begin
      if (w_st == FREE) st_d[wsel_q] = FILLING;
      else              err_d = 1'b1;
    end

    if (wr_done_i) begin
      if (w_st == FILLING) begin
        st_d[wsel_q] = FULL;
        wsel_d       = ~wsel_q;
      end else begin
        err_d = 1'b1;
      end
    end

    // Release overrides the FULL->READING move of a same-cycle read.
    if (rd_release_i) begin
      if (rd_valid_o) begin
        st_d[rsel_q] = FREE;
        rsel_d       = ~rsel_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

endmodule
